riscv_ram_1r1w_client: RTL and testbench

RISCV_RAM_1R1W_CLIENT -- requirements
Module: riscv_ram_1r1w_client

---
 rtl/riscv_ram_1r1w_client.sv | 84 ++++++++
 tb/tb_riscv_ram_1r1w_client.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ram_1r1w_client.sv
// Client-side adapter for a 1R1W synchronous RAM: writes pass straight through,
// reads go through a 2-entry response FIFO so that response backpressure never loses data.
module riscv_ram_1r1w_client #(
   parameter int ABITS = 10,
   parameter int DBITS = 32,
   localparam int BEBITS = (DBITS + 7) / 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic [ABITS-1:0]  wr_addr_i,
   input  logic [DBITS-1:0]  wr_data_i,
   input  logic [BEBITS-1:0] wr_be_i,
   input  logic              rd_valid_i,
   output logic              rd_ready_o,
   input  logic [ABITS-1:0]  rd_addr_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DBITS-1:0]  rsp_data_o,
   output logic              idle_o,
   output logic [ABITS-1:0]  ram_waddr_o,
   output logic [DBITS-1:0]  ram_din_o,
   output logic              ram_we_o,
   output logic [BEBITS-1:0] ram_be_o,
   output logic [ABITS-1:0]  ram_raddr_o,
   output logic              ram_re_o,
   input  logic [DBITS-1:0]  ram_dout_i
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both high;
   // a requester holds valid and its payload stable until that edge.

   logic [DBITS-1:0] r_mem [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_cnt;
   logic             r_inflight;

   logic [1:0]       w_occ;
   logic             w_pop;
   logic             w_push;

   assign wr_ready_o  = ~rst_i;
   assign ram_we_o    = wr_valid_i & ~rst_i;
   assign ram_waddr_o = wr_addr_i;
   assign ram_din_o   = wr_data_i;
   assign ram_be_o    = wr_be_i;

   // Occupancy counts the word still inside the RAM pipeline, so a slot is always reserved for it.
   assign w_occ       = r_cnt + {1'b0, r_inflight};
   assign rsp_valid_o = (r_cnt != 2'd0);
   assign rsp_data_o  = r_mem[r_rptr];
   assign w_pop       = rsp_valid_o & rsp_ready_i;
   assign w_push      = r_inflight;
   assign rd_ready_o  = ~rst_i & ((w_occ < 2'd2) | w_pop);
   assign ram_raddr_o = rd_addr_i;
   assign ram_re_o    = rd_valid_i & rd_ready_o;
   assign idle_o      = (w_occ == 2'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_inflight <= 1'b0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_cnt      <= 2'd0;
      end else begin
         r_inflight <= ram_re_o;
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Data storage is left unreset; it is only observed while rsp_valid_o is high.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= ram_dout_i;
   end

endmodule

// File: tb/tb_riscv_ram_1r1w_client.sv
// Bench for riscv_ram_1r1w_client: behavioural write-first RAM, directed vectors plus
// constrained random traffic, with a queue-based response scoreboard.
module tb_riscv_ram_1r1w_client;

   localparam int ABITS  = 10;
   localparam int DBITS  = 32;
   localparam int BEBITS = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_valid = 1'b0;
   logic              wr_ready_o;
   logic [ABITS-1:0]  wr_addr = '0;
   logic [DBITS-1:0]  wr_data = '0;
   logic [BEBITS-1:0] wr_be = '0;
   logic              rd_valid = 1'b0;
   logic              rd_ready_o;
   logic [ABITS-1:0]  rd_addr = '0;
   logic              rsp_valid_o;
   logic              rsp_ready = 1'b1;
   logic [DBITS-1:0]  rsp_data_o;
   logic              idle_o;
   logic [ABITS-1:0]  ram_waddr_o;
   logic [DBITS-1:0]  ram_din_o;
   logic              ram_we_o;
   logic [BEBITS-1:0] ram_be_o;
   logic [ABITS-1:0]  ram_raddr_o;
   logic              ram_re_o;
   logic [DBITS-1:0]  ram_dout;

   logic [DBITS-1:0]  ram_mem [1024];
   logic [DBITS-1:0]  ref_mem [1024];
   logic [DBITS-1:0]  exp_q [$];
   int                pop_cyc [$];

   int   n_checks = 0;
   int   n_errs   = 0;
   int   cyc      = 0;
   int   n_out    = 0;
   int   tot_acc  = 0;
   logic prev_hold = 1'b0;
   logic [DBITS-1:0] prev_data = '0;
   logic bp_done = 1'b0;

   riscv_ram_1r1w_client #(.ABITS(ABITS), .DBITS(DBITS)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .wr_valid_i  (wr_valid),
      .wr_ready_o  (wr_ready_o),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .wr_be_i     (wr_be),
      .rd_valid_i  (rd_valid),
      .rd_ready_o  (rd_ready_o),
      .rd_addr_i   (rd_addr),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data_o),
      .idle_o      (idle_o),
      .ram_waddr_o (ram_waddr_o),
      .ram_din_o   (ram_din_o),
      .ram_we_o    (ram_we_o),
      .ram_be_o    (ram_be_o),
      .ram_raddr_o (ram_raddr_o),
      .ram_re_o    (ram_re_o),
      .ram_dout_i  (ram_dout)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      n_errs++;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Behavioural RAM: write-first, read data one cycle after ram_re_o.
   initial begin
      for (int i = 0; i < 1024; i++) ram_mem[i] = 32'hA500_0000 | 32'(i);
      ram_dout = '0;
      forever begin
         @(posedge clk);
         if (ram_we_o) ram_mem[ram_waddr_o] = merge(ram_mem[ram_waddr_o], ram_din_o, ram_be_o);
         if (ram_re_o) ram_dout <= ram_mem[ram_raddr_o];
      end
   end

   // Reference memory tracking writes as issued at the client port.
   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
      forever begin
         @(posedge clk);
         if (wr_valid && !rst) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      int acc;
      int pop;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            chk("rst_rd_ready", 32'(rd_ready_o), 32'd0);
            chk("rst_wr_ready", 32'(wr_ready_o), 32'd0);
            chk("rst_ram_we", 32'(ram_we_o), 32'd0);
            chk("rst_ram_re", 32'(ram_re_o), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
            chk("rst_idle", 32'(idle_o), 32'd1);
            exp_q.delete();
            n_out = 0;
            prev_hold = 1'b0;
         end else begin
            acc = (rd_valid && rd_ready_o) ? 1 : 0;
            pop = (rsp_valid_o && rsp_ready) ? 1 : 0;
            chk("wr_ready", 32'(wr_ready_o), 32'd1);
            chk("ram_we", 32'(ram_we_o), 32'(wr_valid));
            chk("ram_waddr", 32'(ram_waddr_o), 32'(wr_addr));
            chk("ram_din", ram_din_o, wr_data);
            chk("ram_be", 32'(ram_be_o), 32'(wr_be));
            chk("ram_raddr", 32'(ram_raddr_o), 32'(rd_addr));
            chk("ram_re", 32'(ram_re_o), 32'(acc));
            chk("idle", 32'(idle_o), 32'(n_out == 0));
            chk("rd_ready", 32'(rd_ready_o), 32'((n_out < 2) || (pop == 1)));
            if (prev_hold) begin
               chk("hold_valid", 32'(rsp_valid_o), 32'd1);
               chk("hold_data", rsp_data_o, prev_data);
            end
            if (pop == 1) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errs++;
                  $display("FAIL unexpected_rsp: got %h want no response (cycle %0d)", rsp_data_o, cyc);
               end else begin
                  chk("rsp_data", rsp_data_o, exp_q.pop_front());
               end
               pop_cyc.push_back(cyc);
            end
            n_out = n_out + acc - pop;
            tot_acc = tot_acc + acc;
            chk("occ_le2", 32'(n_out <= 2), 32'd1);
            prev_hold = rsp_valid_o && !rsp_ready;
            prev_data = rsp_data_o;
         end
      end
   end

   // ---------------- driver tasks (entered and left just after a rising edge) ----------------
   task automatic write_one(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_addr = a;
      wr_data = d;
      wr_be = be;
      wr_valid = 1'b1;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic read_one(input logic [ABITS-1:0] a, input logic [31:0] e, output int waits);
      bit ok;
      ok = 1'b0;
      waits = 0;
      rd_addr = a;
      rd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rd_ready_o) begin
            exp_q.push_back(e);
            ok = 1'b1;
            break;
         end
         waits++;
      end
      if (!ok) begin
         n_checks++;
         n_errs++;
         $display("FAIL read_accept: got no acceptance want accept of addr %h", a);
      end
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0 && idle_o) break;
         @(posedge clk);
         #1;
      end
      chk(nm, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w;
      logic acc_last;
      logic [31:0] e;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rd_ready", 32'(rd_ready_o), 32'd1);
      chk("post_rst_wr_ready", 32'(wr_ready_o), 32'd1);
      @(posedge clk);
      #1;

      // Full-word write then read, with exact two-cycle latency.
      write_one(10'h005, 32'hDEAD_BEEF, 4'hF);
      read_one(10'h005, 32'hDEAD_BEEF, w);
      @(negedge clk);
      chk("lat_cycle1_valid", 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", 32'(rsp_valid_o), 32'd1);
      chk("lat_cycle2_data", rsp_data_o, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      wait_drain("drain_t1");

      // Partial byte-enable write merges into the old word.
      write_one(10'h005, 32'hCAFE_F00D, 4'h5);
      read_one(10'h005, 32'hDEFE_BE0D, w);
      wait_drain("drain_be");

      // Back-to-back reads with the response side always ready.
      pop_cyc.delete();
      for (int a = 1; a <= 4; a++) begin
         read_one(10'(a), 32'hA500_0000 | 32'(a), w);
         chk("b2b_no_wait", 32'(w), 32'd0);
      end
      wait_drain("drain_b2b");
      chk("b2b_rsp_count", 32'(pop_cyc.size()), 32'd4);
      if (pop_cyc.size() == 4)
         for (int i = 1; i < 4; i++)
            chk("b2b_rsp_consecutive", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

      // Backpressure: only two reads fit, the head is held, then everything drains in order.
      rsp_ready = 1'b0;
      begin
         int base;
         base = tot_acc;
         bp_done = 1'b0;
         fork
            begin
               int wf;
               for (int a = 1; a <= 4; a++) read_one(10'(a), 32'hA500_0000 | 32'(a), wf);
               bp_done = 1'b1;
            end
         join_none
         repeat (6) @(negedge clk);
         chk("bp_accepted", 32'(tot_acc - base), 32'd2);
         chk("bp_rd_ready", 32'(rd_ready_o), 32'd0);
         chk("bp_head_valid", 32'(rsp_valid_o), 32'd1);
         chk("bp_head_data", rsp_data_o, 32'hA500_0001);
         @(posedge clk);
         #1;
         rsp_ready = 1'b1;
         for (int i = 0; i < 40; i++) begin
            if (bp_done) break;
            @(posedge clk);
            #1;
         end
         chk("bp_all_accepted", 32'(bp_done), 32'd1);
         wait_drain("drain_bp");
      end

      // Same-cycle write and read of one address reach the RAM unchanged.
      wr_addr = 10'h010;
      wr_data = 32'h1234_5678;
      wr_be = 4'hF;
      wr_valid = 1'b1;
      rd_addr = 10'h010;
      rd_valid = 1'b1;
      @(negedge clk);
      chk("wf_ram_waddr", 32'(ram_waddr_o), 32'h010);
      chk("wf_ram_din", ram_din_o, 32'h1234_5678);
      chk("wf_ram_we", 32'(ram_we_o), 32'd1);
      chk("wf_ram_raddr", 32'(ram_raddr_o), 32'h010);
      chk("wf_ram_re", 32'(ram_re_o), 32'd1);
      exp_q.push_back(32'h1234_5678);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      wait_drain("drain_wf");
      read_one(10'h010, 32'h1234_5678, w);
      wait_drain("drain_wf2");

      // Reset the cycle after a read is accepted: that read must vanish.
      read_one(10'h007, 32'hA500_0007, w);
      rst = 1'b1;
      rd_valid = 1'b1;
      wr_valid = 1'b1;
      #1;
      chk("async_idle", 32'(idle_o), 32'd1);
      chk("async_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("async_rd_ready", 32'(rd_ready_o), 32'd0);
      chk("async_wr_ready", 32'(wr_ready_o), 32'd0);
      chk("async_ram_re", 32'(ram_re_o), 32'd0);
      chk("async_ram_we", 32'(ram_we_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rd_valid = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk);
      chk("rst2_rd_ready", 32'(rd_ready_o), 32'd1);
      chk("rst2_wr_ready", 32'(wr_ready_o), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("rst_no_rsp", 32'(rsp_valid_o), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      read_one(10'h002, 32'hA500_0002, w);
      wait_drain("drain_rst");

      // Random traffic on a small address window so reads and writes collide.
      acc_last = 1'b1;
      for (int it = 0; it < 300; it++) begin
         if (!rd_valid || acc_last) begin
            rd_valid = 1'($urandom_range(0, 1));
            rd_addr = 10'($urandom_range(0, 7));
         end
         wr_valid = 1'($urandom_range(0, 1));
         wr_addr = 10'($urandom_range(0, 7));
         wr_data = $urandom();
         wr_be = 4'($urandom_range(0, 15));
         rsp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc_last = rd_valid && rd_ready_o;
         if (acc_last) begin
            e = ref_mem[rd_addr];
            if (wr_valid && wr_addr == rd_addr) e = merge(e, wr_data, wr_be);
            exp_q.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      rd_valid = 1'b0;
      wr_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_drain("drain_random");
      chk("final_idle", 32'(idle_o), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
